// File: rtl/dcache_pkg.sv
// Shared state encoding and geometry helpers for the N-way data-cache second stage.
package dcache_pkg;

  localparam int unsigned DCACHE_ADDR_W = 32;
  localparam int unsigned DCACHE_WORD_W = 32;
  localparam int unsigned DCACHE_STRB_W = 4;

  typedef enum logic [2:0] {
    StIdle,
    StWbWait,
    StRdWait,
    StUcRd,
    StUcWr,
    StDone
  } dcache_state_e;

  function automatic int unsigned dcache_ofs_w(int unsigned line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int unsigned dcache_tag_w(int unsigned idx_w, int unsigned line_words);
    return DCACHE_ADDR_W - idx_w - dcache_ofs_w(line_words);
  endfunction

  function automatic int unsigned dcache_way_w(int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/dcache_byte_merge.sv
// Byte-lane merge of store data into an existing 32-bit word.
module dcache_byte_merge
  import dcache_pkg::*;
(
  input  logic [DCACHE_WORD_W-1:0] word_i,
  input  logic [DCACHE_WORD_W-1:0] wdata_i,
  input  logic [DCACHE_STRB_W-1:0] wstrb_i,
  output logic [DCACHE_WORD_W-1:0] merged_o
);

  always_comb begin
    merged_o = word_i;
    for (int b = 0; b < DCACHE_STRB_W; b++) begin
      if (wstrb_i[b]) merged_o[8*b +: 8] = wdata_i[8*b +: 8];
    end
  end

endmodule

// File: rtl/dcache_s2_nway.sv
// Data-cache stage 2: N-way hit detect, load select, store merge and the miss/uncached FSM.
module dcache_s2_nway
  import dcache_pkg::*;
#(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned LINE_WORDS = 16,
  parameter int unsigned IDX_W      = 6,
  localparam int unsigned OFS_W     = dcache_ofs_w(LINE_WORDS),
  localparam int unsigned TAG_W     = dcache_tag_w(IDX_W, LINE_WORDS),
  localparam int unsigned WAY_W     = dcache_way_w(WAYS),
  localparam int unsigned LINE_W    = LINE_WORDS * 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid_i,
  input  logic                      req_cached_i,
  input  logic                      req_we_i,
  input  logic [3:0]                req_wstrb_i,
  input  logic [31:0]               req_addr_i,
  input  logic [31:0]               req_wdata_i,
  input  logic [WAYS*(TAG_W+1)-1:0] tagv_i,
  input  logic [WAYS-1:0]           dirty_i,
  input  logic [WAYS*32-1:0]        data_i,
  input  logic [WAY_W-1:0]          victim_i,
  output logic                      ca_rreq_o,
  output logic                      ca_wreq_o,
  output logic                      uc_rreq_o,
  output logic                      uc_wreq_o,
  output logic [31:0]               bus_addr_o,
  output logic [31:0]               bus_wdata_o,
  output logic [3:0]                bus_wstrb_o,
  output logic [WAY_W-1:0]          wb_way_o,
  input  logic                      rend_i,
  input  logic                      wend_i,
  input  logic [LINE_W-1:0]         line_i,
  input  logic [31:0]               uc_rdata_i,
  output logic                      hit_o,
  output logic [WAY_W-1:0]          hit_way_o,
  output logic                      hit_we_o,
  output logic [31:0]               hit_wdata_o,
  output logic                      refill_o,
  output logic [WAY_W-1:0]          refill_way_o,
  output logic [LINE_W-1:0]         refill_line_o,
  output logic                      stall_o,
  output logic [31:0]               rdata_o,
  output logic                      rdata_valid_o
);

  localparam int unsigned TV_W   = TAG_W + 1;
  localparam int unsigned WSEL_W = OFS_W - 2;

  dcache_state_e     state_q;
  logic [WAY_W-1:0]  victim_q;
  logic              cached_q, we_q;
  logic [LINE_W-1:0] line_q;
  logic [31:0]       word_q;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] req_word;
  assign req_tag  = req_addr_i[31 -: TAG_W];
  assign req_idx  = req_addr_i[OFS_W +: IDX_W];
  assign req_word = req_addr_i[2 +: WSEL_W];

  logic [WAYS-1:0]  way_valid, hit_vec;
  logic [TAG_W-1:0] way_tag  [WAYS];
  logic [31:0]      way_data [WAYS];
  logic [WAY_W-1:0] hit_way;

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_tag[w]   = tagv_i[w*TV_W +: TAG_W];
      way_valid[w] = tagv_i[w*TV_W + TAG_W];
      way_data[w]  = data_i[w*32 +: 32];
      hit_vec[w]   = way_valid[w] && (way_tag[w] == req_tag);
    end
    // Descending scan so the lowest hitting way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  logic live, any_hit, miss, vic_dirty, done, load_hit, load_done;
  assign live      = !rst && (state_q == StIdle) && req_valid_i;
  assign any_hit   = |hit_vec;
  assign miss      = live && req_cached_i && !any_hit;
  assign vic_dirty = way_valid[victim_i] && dirty_i[victim_i];
  assign done      = !rst && (state_q == StDone);

  assign hit_o     = live && req_cached_i && any_hit;
  assign ca_wreq_o = miss && vic_dirty;
  assign ca_rreq_o = (miss && !vic_dirty) || (!rst && state_q == StWbWait && wend_i);
  assign uc_rreq_o = live && !req_cached_i && !req_we_i;
  assign uc_wreq_o = live && !req_cached_i && req_we_i;

  logic [31:0]       hit_merged, fill_merged;
  logic [LINE_W-1:0] fill_line;

  dcache_byte_merge u_hit_merge (
    .word_i   (way_data[hit_way]),
    .wdata_i  (req_wdata_i),
    .wstrb_i  (req_wstrb_i),
    .merged_o (hit_merged)
  );

  dcache_byte_merge u_fill_merge (
    .word_i   (line_i[32*req_word +: 32]),
    .wdata_i  (req_wdata_i),
    .wstrb_i  (req_wstrb_i),
    .merged_o (fill_merged)
  );

  always_comb begin
    fill_line = line_i;
    if (we_q) fill_line[32*req_word +: 32] = fill_merged;
  end

  always_comb begin
    bus_addr_o = '0;
    if (ca_wreq_o)                   bus_addr_o = {way_tag[victim_i], req_idx, {OFS_W{1'b0}}};
    else if (ca_rreq_o)              bus_addr_o = {req_addr_i[31:OFS_W], {OFS_W{1'b0}}};
    else if (uc_rreq_o || uc_wreq_o) bus_addr_o = req_addr_i;
  end

  assign bus_wdata_o   = uc_wreq_o ? req_wdata_i : '0;
  assign bus_wstrb_o   = uc_wreq_o ? req_wstrb_i : '0;
  assign wb_way_o      = ca_wreq_o ? victim_i :
                         (!rst && state_q == StWbWait) ? victim_q : '0;
  assign hit_way_o     = hit_o ? hit_way : '0;
  assign hit_we_o      = hit_o && req_we_i;
  assign hit_wdata_o   = hit_we_o ? hit_merged : '0;
  assign refill_o      = done && cached_q;
  assign refill_way_o  = refill_o ? victim_q : '0;
  assign refill_line_o = refill_o ? line_q : '0;
  assign load_hit      = hit_o && !req_we_i;
  assign load_done     = done && !we_q;
  assign rdata_valid_o = load_hit || load_done;
  assign rdata_o       = load_hit ? way_data[hit_way] : (load_done ? word_q : '0);
  assign stall_o       = (live && !(req_cached_i && any_hit)) ||
                         (!rst && state_q != StIdle && state_q != StDone);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      victim_q <= '0;
      cached_q <= 1'b0;
      we_q     <= 1'b0;
      line_q   <= '0;
      word_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Victim and dirty state are captured here; s1 may move on while we wait.
          if (miss) begin
            victim_q <= victim_i;
            cached_q <= 1'b1;
            we_q     <= req_we_i;
            state_q  <= vic_dirty ? StWbWait : StRdWait;
          end else if (uc_rreq_o || uc_wreq_o) begin
            cached_q <= 1'b0;
            we_q     <= req_we_i;
            state_q  <= uc_wreq_o ? StUcWr : StUcRd;
          end
        end
        StWbWait: if (wend_i) state_q <= StRdWait;
        StRdWait: begin
          if (rend_i) begin
            line_q  <= fill_line;
            word_q  <= fill_line[32*req_word +: 32];
            state_q <= StDone;
          end
        end
        StUcRd: begin
          if (rend_i) begin
            word_q  <= uc_rdata_i;
            state_q <= StDone;
          end
        end
        StUcWr:  if (wend_i) state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Set contents must never hold two valid copies of one tag.
  assert property (@(posedge clk) disable iff (rst)
    (state_q == StIdle && req_valid_i && req_cached_i) |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_dcache_s2_nway.sv
// Randomized bench for dcache_s2_nway (4-way) against a transaction-level reference model.
module tb_dcache_s2_nway;
  import dcache_pkg::*;

  localparam int unsigned WAYS = 4, LW = 16, IDXW = 6, TAGW = 20, WAYW = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid_i = 0, req_cached_i = 0, req_we_i = 0;
  logic [3:0] req_wstrb_i = '0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0, uc_rdata_i = '0;
  logic [WAYS*(TAGW+1)-1:0] tagv_i = '0;
  logic [WAYS-1:0] dirty_i = '0;
  logic [WAYS*32-1:0] data_i = '0;
  logic [WAYW-1:0] victim_i = '0;
  logic rend_i = 0, wend_i = 0;
  logic [LW*32-1:0] line_i = '0;
  logic ca_rreq_o, ca_wreq_o, uc_rreq_o, uc_wreq_o, hit_o, hit_we_o, refill_o, stall_o;
  logic rdata_valid_o;
  logic [31:0] bus_addr_o, bus_wdata_o, hit_wdata_o, rdata_o;
  logic [3:0] bus_wstrb_o;
  logic [WAYW-1:0] wb_way_o, hit_way_o, refill_way_o;
  logic [LW*32-1:0] refill_line_o;

  always #5 clk = ~clk;

  dcache_s2_nway #(.WAYS(WAYS), .LINE_WORDS(LW), .IDX_W(IDXW)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_cached_i(req_cached_i),
    .req_we_i(req_we_i), .req_wstrb_i(req_wstrb_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .tagv_i(tagv_i), .dirty_i(dirty_i), .data_i(data_i),
    .victim_i(victim_i), .ca_rreq_o(ca_rreq_o), .ca_wreq_o(ca_wreq_o), .uc_rreq_o(uc_rreq_o),
    .uc_wreq_o(uc_wreq_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_wstrb_o(bus_wstrb_o), .wb_way_o(wb_way_o), .rend_i(rend_i), .wend_i(wend_i),
    .line_i(line_i), .uc_rdata_i(uc_rdata_i), .hit_o(hit_o), .hit_way_o(hit_way_o),
    .hit_we_o(hit_we_o), .hit_wdata_o(hit_wdata_o), .refill_o(refill_o),
    .refill_way_o(refill_way_o), .refill_line_o(refill_line_o), .stall_o(stall_o),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o)
  );

  typedef struct packed {
    logic hit; logic [1:0] hit_way; logic hit_we; logic [31:0] hit_wdata;
    logic ca_r, ca_w, uc_r, uc_w; logic [31:0] addr, wdata; logic [3:0] wstrb;
    logic [1:0] wb_way; logic refill; logic [1:0] refill_way; logic [511:0] line;
    logic stall; logic [31:0] rdata; logic rvalid;
  } exp_t;

  exp_t ex = '0;
  int n_chk = 0, n_fail = 0;
  int n_car = 0, n_caw = 0, n_ucw = 0, n_ref = 0;
  logic [31:0] cap_rdata = '0, cap_hwd = '0, cap_car = '0, cap_caw = '0;
  logic [1:0] cap_hitway = '0;
  logic cap_hit_stall = 1'b1;

  // Set contents as seen by s1 for the current request.
  logic [19:0] b_tag [4];
  bit          b_val [4];
  bit          b_dirty [4];
  logic [31:0] b_data [4];
  int          b_victim;

  function automatic void chk(string nm, logic [511:0] act, logic [511:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  always @(negedge clk) begin
    chk("hit_o", hit_o, ex.hit);
    chk("hit_way_o", hit_way_o, ex.hit_way);
    chk("hit_we_o", hit_we_o, ex.hit_we);
    chk("hit_wdata_o", hit_wdata_o, ex.hit_wdata);
    chk("ca_rreq_o", ca_rreq_o, ex.ca_r);
    chk("ca_wreq_o", ca_wreq_o, ex.ca_w);
    chk("uc_rreq_o", uc_rreq_o, ex.uc_r);
    chk("uc_wreq_o", uc_wreq_o, ex.uc_w);
    chk("bus_addr_o", bus_addr_o, ex.addr);
    chk("bus_wdata_o", bus_wdata_o, ex.wdata);
    chk("bus_wstrb_o", bus_wstrb_o, ex.wstrb);
    chk("wb_way_o", wb_way_o, ex.wb_way);
    chk("refill_o", refill_o, ex.refill);
    chk("refill_way_o", refill_way_o, ex.refill_way);
    chk("refill_line_o", refill_line_o, ex.line);
    chk("stall_o", stall_o, ex.stall);
    chk("rdata_o", rdata_o, ex.rdata);
    chk("rdata_valid_o", rdata_valid_o, ex.rvalid);
    if (rdata_valid_o) cap_rdata = rdata_o;
    if (hit_o) begin cap_hitway = hit_way_o; cap_hit_stall = stall_o; end
    if (hit_we_o) cap_hwd = hit_wdata_o;
    if (ca_rreq_o) begin n_car++; cap_car = bus_addr_o; end
    if (ca_wreq_o) begin n_caw++; cap_caw = bus_addr_o; end
    if (uc_wreq_o) n_ucw++;
    if (refill_o) n_ref++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_set();
    for (int w = 0; w < 4; w++) begin
      tagv_i[w*21 +: 21] = {b_val[w], b_tag[w]};
      dirty_i[w]         = b_dirty[w];
      data_i[w*32 +: 32] = b_data[w];
    end
    victim_i = b_victim[1:0];
  endtask

  // s1 keeps moving while we wait; the stage must rely on what it sampled at the miss.
  task automatic scramble();
    victim_i = 2'($urandom);
    dirty_i  = 4'($urandom);
    for (int w = 0; w < 4; w++) data_i[w*32 +: 32] = $urandom;
  endtask

  task automatic base_set();
    for (int w = 0; w < 4; w++) begin
      b_tag[w] = 20'h50000 + 20'(w); b_val[w] = 1; b_dirty[w] = 0; b_data[w] = $urandom;
    end
    b_victim = 0;
  endtask

  task automatic rand_set(input logic [19:0] tg, input int hw);
    for (int w = 0; w < 4; w++) begin
      b_tag[w]   = {w[1:0], 18'($urandom)};
      b_val[w]   = ($urandom_range(0, 3) != 0);
      b_dirty[w] = $urandom_range(0, 1);
      b_data[w]  = $urandom;
      if (w != hw && b_tag[w] == tg) b_tag[w][0] = ~b_tag[w][0];
    end
    if (hw >= 0) begin b_tag[hw] = tg; b_val[hw] = 1; end
    b_victim = $urandom_range(0, 3);
  endtask

  task automatic txn(input bit cached, input bit we, input logic [31:0] addr,
                     input logic [3:0] strb, input logic [31:0] wd, input int lat);
    int hw, v;
    bit dv;
    logic [19:0] tg;
    logic [5:0] idx;
    logic [3:0] wi;
    logic [511:0] ln, lm;
    logic [31:0] uw;
    tg = addr[31:12]; idx = addr[11:6]; wi = addr[5:2]; v = b_victim;
    hw = -1;
    for (int w = 0; w < 4; w++) if (hw < 0 && b_val[w] && b_tag[w] == tg) hw = w;
    apply_set();
    req_valid_i = 1; req_cached_i = cached; req_we_i = we;
    req_addr_i = addr; req_wstrb_i = strb; req_wdata_i = wd;
    rend_i = 0; wend_i = 0;
    ex = '0;
    if (cached && hw >= 0) begin
      ex.hit = 1; ex.hit_way = hw[1:0]; ex.hit_we = we;
      if (we) ex.hit_wdata = bmerge(b_data[hw], wd, strb);
      else begin ex.rvalid = 1; ex.rdata = b_data[hw]; end
    end else begin
      dv = cached && b_val[v] && b_dirty[v];
      ex.stall = 1;
      if (!cached) begin
        ex.addr = addr;
        if (we) begin ex.uc_w = 1; ex.wdata = wd; ex.wstrb = strb; end
        else ex.uc_r = 1;
      end else if (dv) begin
        ex.ca_w = 1; ex.addr = {b_tag[v], idx, 6'b0}; ex.wb_way = v[1:0];
      end else begin
        ex.ca_r = 1; ex.addr = {addr[31:6], 6'b0};
      end
      cyc();
      if (dv) begin
        for (int i = 0; i < lat; i++) begin
          scramble(); rend_i = 1'($urandom);
          ex = '0; ex.stall = 1; ex.wb_way = v[1:0];
          cyc();
        end
        scramble(); rend_i = 0; wend_i = 1;
        ex = '0; ex.stall = 1; ex.wb_way = v[1:0]; ex.ca_r = 1; ex.addr = {addr[31:6], 6'b0};
        cyc();
        wend_i = 0;
      end
      for (int i = 0; i < lat; i++) begin
        scramble();
        if (cached || !we) wend_i = 1'($urandom); else rend_i = 1'($urandom);
        ex = '0; ex.stall = 1;
        cyc();
      end
      for (int k = 0; k < 16; k++) ln[32*k +: 32] = $urandom;
      uw = $urandom;
      line_i = ln; uc_rdata_i = uw;
      if (cached || !we) begin rend_i = 1; wend_i = 0; end else begin wend_i = 1; rend_i = 0; end
      ex = '0; ex.stall = 1;
      cyc();
      lm = ln;
      if (cached && we) lm[32*wi +: 32] = bmerge(ln[32*wi +: 32], wd, strb);
      rend_i = 1'($urandom); wend_i = 1'($urandom);
      for (int k = 0; k < 16; k++) line_i[32*k +: 32] = $urandom;
      uc_rdata_i = $urandom;
      ex = '0;
      if (cached) begin ex.refill = 1; ex.refill_way = v[1:0]; ex.line = lm; end
      if (!we) begin ex.rvalid = 1; ex.rdata = cached ? lm[32*wi +: 32] : uw; end
    end
    cyc();
    req_valid_i = 0; rend_i = 1'($urandom); wend_i = 1'($urandom);
    ex = '0;
    cyc();
    rend_i = 0; wend_i = 0;
  endtask

  initial begin
    int c0, c1, c2, c3;
    logic [31:0] a;
    bit ca, we;
    int hw;
    ex = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    cyc();

    // Load hit in way 2
    base_set(); b_tag[2] = 20'h10000; b_data[2] = 32'hDEADBEEF;
    txn(1, 0, 32'h1000_0044, 4'h0, 32'h0, 0);
    chk("t1_rdata", cap_rdata, 32'hDEADBEEF);
    chk("t1_hit_way", cap_hitway, 2'd2);
    chk("t1_stall", cap_hit_stall, 1'b0);

    // Store hit, byte merge
    base_set(); b_tag[1] = 20'h10000; b_data[1] = 32'hAABBCCDD;
    txn(1, 1, 32'h1000_0044, 4'b0011, 32'h1234_5678, 0);
    chk("t2_hit_wdata", cap_hwd, 32'hAABB5678);

    // Clean miss
    base_set(); b_victim = 1; c0 = n_car; c1 = n_ref;
    txn(1, 0, 32'h1000_0044, 4'h0, 32'h0, 5);
    chk("t3_ca_rreq_count", n_car - c0, 1);
    chk("t3_ca_raddr", cap_car, 32'h1000_0040);
    chk("t3_refill_count", n_ref - c1, 1);

    // Dirty victim writeback then refill
    base_set(); b_tag[0] = 20'h3; b_dirty[0] = 1; b_victim = 0;
    c0 = n_car; c1 = n_caw; c2 = n_ref;
    txn(1, 1, 32'h1000_0044, 4'hF, 32'hCAFE_F00D, 3);
    chk("t4_ca_waddr", cap_caw, 32'h0000_3040);
    chk("t4_ca_wreq_count", n_caw - c1, 1);
    chk("t4_ca_rreq_count", n_car - c0, 1);
    chk("t4_refill_count", n_ref - c2, 1);

    // Uncached store
    base_set(); c0 = n_ucw; c1 = n_ref;
    txn(0, 1, 32'h2000_0010, 4'hF, 32'h0BAD_F00D, 3);
    chk("t5_uc_wreq_count", n_ucw - c0, 1);
    chk("t5_refill_count", n_ref - c1, 0);

    // Reset while waiting for a line
    base_set(); b_victim = 1; apply_set();
    req_valid_i = 1; req_cached_i = 1; req_we_i = 0; req_addr_i = 32'h1000_0044;
    ex = '0; ex.stall = 1; ex.ca_r = 1; ex.addr = 32'h1000_0040;
    cyc();
    ex = '0; ex.stall = 1;
    cyc(); cyc();
    rst = 1; ex = '0;
    cyc();
    rst = 0; req_valid_i = 0;
    cyc();
    c0 = n_car;
    base_set(); b_victim = 2;
    txn(1, 0, 32'h1000_0088, 4'h0, 32'h0, 2);
    chk("t6_after_reset_ca_rreq", n_car - c0, 1);
    chk("t6_after_reset_raddr", cap_car, 32'h1000_0080);

    repeat (200) begin
      ca = ($urandom_range(0, 3) != 0);
      we = 1'($urandom);
      a  = $urandom;
      hw = $urandom_range(0, 1) ? int'($urandom_range(0, 3)) : -1;
      rand_set(a[31:12], hw);
      c3 = $urandom_range(0, 6);
      txn(ca, we, a, 4'($urandom), $urandom, c3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
